// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: segment codes
// (active-low form, bit 6 = a ... bit 0 = g), converter state encoding and
// BCD sizing helper.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Conversion FSM state encoding
  typedef logic [1:0] conv_state_t;
  localparam conv_state_t IDLE   = 2'd0;
  localparam conv_state_t SHIFT  = 2'd1;
  localparam conv_state_t COMMIT = 2'd2;

  // Number of BCD digits needed to hold any bin_w-bit value
  function automatic int bcd_digits(input int bin_w);
    return (bin_w * 32'sd3) / 32'sd10 + 32'sd1;
  endfunction

  // Active-low segment pattern for one BCD digit; non-decimal nibbles blank
  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seven_seg_mux_driver_bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter. A start accepted in IDLE
// runs BIN_W shift cycles and one COMMIT cycle; done is high during COMMIT,
// when bcd holds the finished result, and busy falls at the end of it.
module bcd_seq_converter
  import seven_seg_pkg::*;
#(
  parameter int BIN_W = 13,
  parameter int BCD_D = bcd_digits(BIN_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIN_W-1:0]     num,
  output logic                 busy,
  output logic                 done,
  output logic [4*BCD_D-1:0]   bcd
);

  localparam int BCD_W = 4 * BCD_D;
  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_t        r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_busy;
  logic [BCD_W-1:0]   w_adj;

  // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift
  always_comb begin
    w_adj = '0;
    for (int d = 0; d < BCD_D; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end else begin
        w_adj[4*d +: 4] = r_bcd[4*d +: 4];
      end
    end
  end

  // Conversion FSM: capture, BIN_W shifts, one commit cycle, back to idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin   <= num;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            r_cnt   <= '0;
            r_state <= COMMIT;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        COMMIT: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = (r_state == COMMIT);
  assign bcd  = r_bcd;

endmodule

// File: rtl/seven_seg_mux_driver.sv
// Multiplexed seven-segment display driver: converts a binary operand to BCD,
// latches it into the display register at commit, and scans N_DIGITS digits
// with leading-zero blanking, per-digit decimal points and overflow dashes.
module seven_seg_mux_driver
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int BIN_W         = 13,
  parameter int REFRESH_DIV_W = 18,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit BLANK_LZ      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIN_W-1:0]     num,
  input  logic                 load,
  input  logic [N_DIGITS-1:0]  dp_mask,
  output logic                 busy,
  output logic                 overflow,
  output logic [N_DIGITS-1:0]  Anode,
  output logic [6:0]           LED_out,
  output logic                 dp_out
);

  localparam int BCD_D = bcd_digits(BIN_W);
  localparam int EXT_D = (BCD_D > N_DIGITS) ? BCD_D : N_DIGITS;
  localparam int IDX_W = $clog2(N_DIGITS);

  logic                      w_done;
  logic [4*BCD_D-1:0]        w_bcd;
  logic [4*EXT_D-1:0]        w_bcd_ext;
  logic                      w_ovf;

  logic [4*N_DIGITS-1:0]     r_disp;
  logic                      r_ovf;
  logic [REFRESH_DIV_W-1:0]  r_presc;
  logic [IDX_W-1:0]          r_idx;

  logic [IDX_W-1:0]          w_pos;
  logic [3:0]                w_nib;
  logic                      w_lead_zero;
  logic [6:0]                w_seg;
  logic [N_DIGITS-1:0]       w_anode_hi;

  bcd_seq_converter #(
    .BIN_W (BIN_W),
    .BCD_D (BCD_D)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (load),
    .num   (num),
    .busy  (busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  // Zero-extend so narrow operands still fill every displayed digit
  assign w_bcd_ext = (4*EXT_D)'(w_bcd);

  // Overflow when any BCD nibble beyond the displayed digits is nonzero
  always_comb begin
    w_ovf = 1'b0;
    for (int d = N_DIGITS; d < EXT_D; d++) begin
      if (w_bcd_ext[4*d +: 4] != 4'd0) begin
        w_ovf = 1'b1;
      end else begin
        w_ovf = w_ovf;
      end
    end
  end

  // Display register and overflow flag change only on the converter commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp <= '0;
      r_ovf  <= 1'b0;
    end else if (w_done) begin
      r_disp <= w_bcd_ext[4*N_DIGITS-1:0];
      r_ovf  <= w_ovf;
    end else begin
      r_disp <= r_disp;
      r_ovf  <= r_ovf;
    end
  end

  // Free-running prescaler; digit index advances on each prescaler wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= r_presc + REFRESH_DIV_W'(1);
      if (r_presc == {REFRESH_DIV_W{1'b1}}) begin
        if (r_idx == IDX_W'(N_DIGITS - 1)) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end else begin
        r_idx <= r_idx;
      end
    end
  end

  // Pick the scanned digit: index 0 is leftmost, i.e. the most significant
  // nibble, which is also the anode bit position; apply blanking and dashes
  always_comb begin
    w_pos       = IDX_W'(N_DIGITS - 1) - r_idx;
    w_nib       = r_disp[4*w_pos +: 4];
    w_lead_zero = 1'b1;
    for (int d = 0; d < N_DIGITS; d++) begin
      if ((d >= int'(w_pos)) && (r_disp[4*d +: 4] != 4'd0)) begin
        w_lead_zero = 1'b0;
      end else begin
        w_lead_zero = w_lead_zero;
      end
    end
    if (r_ovf) begin
      w_seg = SEG_DASH;
    end else if (BLANK_LZ && w_lead_zero && (w_pos != '0)) begin
      w_seg = SEG_BLANK;
    end else begin
      w_seg = seg_code(w_nib);
    end
    w_anode_hi        = '0;
    w_anode_hi[w_pos] = 1'b1;
  end

  // Registered outputs, one cycle behind the digit index, polarity applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Anode   <= {N_DIGITS{ACTIVE_LOW}};
      LED_out <= {7{ACTIVE_LOW}};
      dp_out  <= ACTIVE_LOW;
    end else begin
      Anode   <= ACTIVE_LOW ? ~w_anode_hi : w_anode_hi;
      LED_out <= ACTIVE_LOW ? w_seg : ~w_seg;
      dp_out  <= ACTIVE_LOW ? ~dp_mask[r_idx] : dp_mask[r_idx];
    end
  end

  assign overflow = r_ovf;

endmodule
